// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   It latches a 16-bit value on a load strobe. It then scans the four hex
//   digits one at a time. Each digit slot starts with a one-cycle dead gap
//   (all anodes off) so that the previous digit does not ghost into the next.
//   Leading-zero blanking is optional.
//
// Parameters
//   REFRESH_DIV   - clock cycles per digit slot, dead cycle included (>= 2)
//   BLANK_LEADING - 1: blank leading zero digits (digit 0 always shown)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   value_in   in   [15:0] value to display
//   load       in   capture value_in at the next edge
//   blank      in   force all anodes off (scanning continues)
//   value_q    out  [15:0] currently latched value
//   digit_sel  out  [1:0] current digit slot, 0 = rightmost
//   an         out  [3:0] anode enables, active-low, one-hot
//   seg        out  [6:0] segments, active-low, {g,f,e,d,c,b,a}
module seg_display_scanner #(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank,
    output logic [15:0] value_q,
    output logic [1:0]  digit_sel,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned   CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [1:0]    sel_nx;
    logic [15:0]   shifted;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Refresh counter and digit index; load/blank never touch these.
    always_comb begin
        cnt_nx = cnt + 1'b1;
        sel_nx = digit_sel;
        if (cnt == CNT_MAX) begin
            cnt_nx = '0;
            sel_nx = digit_sel + 2'd1;
        end
    end

    // Outputs are registered from next-state cnt/digit_sel so that the
    // dead cycle lines up with the edge at which digit_sel advances.
    // The value shown is the already-latched value_q, giving one extra
    // cycle of load-to-segment latency.
    always_comb begin
        an_nx   = '1;
        seg_nx  = '1;
        shifted = value_q >> {sel_nx, 2'b00};
        if (!blank && (cnt_nx != '0)) begin
            an_nx  = ~(4'b0001 << sel_nx);
            seg_nx = hex7(shifted[3:0]);
            // Every nibble at or above this digit is zero: leading zero.
            if (BLANK_LEADING && (sel_nx != 2'd0) && (shifted == '0))
                seg_nx = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q   <= '0;
            cnt       <= '0;
            digit_sel <= '0;
            an        <= '1;
            seg       <= '1;
        end else begin
            if (load)
                value_q <= value_in;
            cnt       <= cnt_nx;
            digit_sel <= sel_nx;
            an        <= an_nx;
            seg       <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (REFRESH_DIV=4).
// Two instances share the stimulus: one with leading-zero blanking and one
// without. A time-based reference model predicts every output after each edge.
module tb_seg_display_scanner;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        load;
    logic        blank;

    logic [15:0] value_q_a, value_q_b;
    logic [1:0]  digit_sel_a, digit_sel_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: edges since reset release, and latched value.
    int          t     = 0;
    logic [15:0] m_val = '0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_display_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .reset(reset), .value_in(value_in), .load(load), .blank(blank),
        .value_q(value_q_a), .digit_sel(digit_sel_a), .an(an_a), .seg(seg_a)
    );

    seg_display_scanner #(.REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .reset(reset), .value_in(value_in), .load(load), .blank(blank),
        .value_q(value_q_b), .digit_sel(digit_sel_b), .an(an_b), .seg(seg_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare both instances 1 time unit later.
    task automatic step();
        logic [15:0] old_val;
        logic [15:0] upper;
        int          c, s;
        logic [3:0]  e_an;
        logic [6:0]  e_seg_a, e_seg_b;
        @(posedge clk);
        old_val = m_val;
        if (reset) begin
            t     = 0;
            m_val = '0;
        end else begin
            t = t + 1;
            if (load) m_val = value_in;
        end
        c = t % RD;
        s = (t / RD) % 4;
        e_an    = 4'hF;
        e_seg_a = 7'h7F;
        e_seg_b = 7'h7F;
        if (!reset && !blank && c != 0) begin
            e_an    = 4'hF & ~(4'd1 << s);
            upper   = old_val >> (4 * s);
            e_seg_b = hex_tab[upper[3:0]];
            e_seg_a = (s > 0 && upper == 16'd0) ? 7'h7F : e_seg_b;
        end
        #1;
        check("an_a",        32'(an_a),        32'(e_an));
        check("seg_a",       32'(seg_a),       32'(e_seg_a));
        check("digit_sel_a", 32'(digit_sel_a), 32'(s));
        check("value_q_a",   32'(value_q_a),   32'(m_val));
        check("an_b",        32'(an_b),        32'(e_an));
        check("seg_b",       32'(seg_b),       32'(e_seg_b));
        check("digit_sel_b", 32'(digit_sel_b), 32'(s));
        check("value_q_b",   32'(value_q_b),   32'(m_val));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_val(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        blank    = 1'b0;
        value_in = '0;

        // Reset for two cycles, then a value of zero shows "0" on digit 0.
        run(2);
        reset = 1'b0;
        run(8);

        // Full scan of 1234.
        load_val(16'h1234);
        run(34);

        // Leading zeros.
        load_val(16'h0050);
        run(18);

        // Mid-digit load: wait for digit 0 lit, then load 123F.
        load_val(16'h1234);
        for (int i = 0; i < 64 && !((t / RD) % 4 == 0 && t % RD == 2); i++) step();
        load_val(16'h123F);
        run(6);

        // Blank for 6 cycles mid-scan.
        blank = 1'b1;
        run(6);
        blank = 1'b0;
        run(10);

        // Reset while digit 2 is selected.
        for (int i = 0; i < 64 && ((t / RD) % 4) != 2; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(10);

        // Load on the same edge the digit advances.
        for (int i = 0; i < 64 && (t % RD) != RD - 1; i++) step();
        load_val(16'hABCD);
        run(6);

        // Randomized traffic, biased toward small values to exercise blanking.
        for (int i = 0; i < 3000; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            blank    = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            value_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
